// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory controller.
package mem_pkg;

   // Controller states: waiting for a strobe, bus transaction open, completion cycle.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } memstate_t;

   // Load data returned to the core when a read times out (sized to the widest bus we expect).
   localparam logic [63:0] TIMEOUT_RDATA = '0;

   // Counter width able to hold 0..t; never below one bit so TIMEOUT=0 still elaborates.
   function automatic int cnt_width(input int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/timeout_cnt.sv
// Access watchdog: counts ACCESS cycles and flags the last permitted one.
module timeout_cnt
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam int CW = cnt_width(TIMEOUT);

   logic [CW-1:0] r_count;

   // Cycle counter: cleared when an access opens, advances every ACCESS cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (TIMEOUT != 0)) begin
         r_count <= r_count + CW'(1);
      end
   end

   // Terminal count is the TIMEOUT-th ACCESS cycle; TIMEOUT=0 disables the watchdog.
   generate
      if (TIMEOUT == 0) begin : g_no_limit
         assign o_terminal = 1'b0;
      end else begin : g_limit
         assign o_terminal = (r_count == CW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: converts MEM-stage load/store strobes into a req/ack
// bus transaction, stalls the pipeline while it is open, and bounds it with a watchdog.
//
// Bus handshake: BusReq is raised on the edge entering ACCESS and held, together with
// stable BusWe/BusAddr/BusWData, until the edge on which BusAck=1 is sampled (or the
// watchdog expires). BusRData is only meaningful in a cycle with BusAck=1; BusAck seen
// while no request is open is ignored.
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [ADDR_W-1:0] MemAddr,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              MemRead,
   input  logic              MemWrite,
   output logic [DATA_W-1:0] MemData,
   output logic              Stall,
   output logic              Timeout,
   output logic              BusReq,
   output logic              BusWe,
   output logic [ADDR_W-1:0] BusAddr,
   output logic [DATA_W-1:0] BusWData,
   input  logic              BusAck,
   input  logic [DATA_W-1:0] BusRData,
   output memstate_t         o_dbg_state
);

   memstate_t         r_state;
   memstate_t         w_next_state;
   logic              w_stall;
   logic              w_strobe;
   logic              w_launch;
   logic              w_in_access;
   logic              w_ack;
   logic              w_expire;
   logic              w_terminal;
   logic [DATA_W-1:0] r_mem_data;
   logic              r_timeout;
   logic              r_bus_req;
   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;

   assign w_strobe    = MemRead | MemWrite;
   assign w_in_access = (r_state == ACCESS);
   assign w_launch    = (r_state == IDLE) & w_strobe;
   assign w_ack       = w_in_access & BusAck;
   // An ack in the final permitted cycle wins over the watchdog.
   assign w_expire    = w_in_access & ~BusAck & w_terminal;

   timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .i_clk      (Clock),
      .i_rst_n    (nReset),
      .i_clear    (w_launch),
      .i_enable   (w_in_access),
      .o_terminal (w_terminal)
   );

   // State register; reset abandons any open transaction.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and stall decode. DONE always returns to IDLE so strobes still
   // held by the completing instruction cannot start a second transaction.
   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      case (r_state)
         IDLE: begin
            w_stall = w_strobe;
            if (w_strobe) begin
               w_next_state = ACCESS;
            end
         end
         ACCESS: begin
            w_stall = 1'b1;
            if (BusAck || w_terminal) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            w_stall      = 1'b0;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Transaction latches: captured once at launch, so they stay stable while BusReq=1.
   // A store wins when both strobes are (illegally) set.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
      end else if (w_launch) begin
         r_bus_we    <= MemWrite;
         r_bus_addr  <= MemAddr;
         r_bus_wdata <= WriteData;
      end
   end

   // Bus request: rises entering ACCESS, falls on ack or watchdog expiry.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_bus_req <= 1'b0;
      end else if (w_launch) begin
         r_bus_req <= 1'b1;
      end else if (w_ack || w_expire) begin
         r_bus_req <= 1'b0;
      end
   end

   // Load data register: updated only by completing reads; stores leave it alone.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_mem_data <= '0;
      end else if (w_ack && !r_bus_we) begin
         r_mem_data <= BusRData;
      end else if (w_expire && !r_bus_we) begin
         r_mem_data <= DATA_W'(TIMEOUT_RDATA);
      end
   end

   // Timeout flag: set on expiry, so it is visible exactly during the DONE cycle.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_timeout <= 1'b0;
      end else if (w_expire) begin
         r_timeout <= 1'b1;
      end else if (r_state == DONE) begin
         r_timeout <= 1'b0;
      end
   end

   // Stall is gated by reset so the pipeline is released immediately.
   assign Stall       = w_stall & nReset;
   assign MemData     = r_mem_data;
   assign Timeout     = r_timeout;
   assign BusReq      = r_bus_req;
   assign BusWe       = r_bus_we;
   assign BusAddr     = r_bus_addr;
   assign BusWData    = r_bus_wdata;
   assign o_dbg_state = r_state;

endmodule
